axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4-subset responder (slave) backed by an internal word-addressed SRAM array.
- Serves the core's load/store master: one transaction at a time.
- Fixed-latency read data, byte-strobed writes, FIXED/INCR bursts, SLVERR on out-of-range or unsupported requests.
- Sits between the execute stage's AXI port and the simulation memory model; replaces DPI memory for standalone NPC runs.

Parameters:
DATA_WIDTH, 32, data bus width (only 32 supported)
MEM_WORDS, 1024, array depth in 32-bit words
BASE_ADDR, 32'h8000_0000, byte address of word 0
RD_LATENCY, 1, cycles from AR handshake to first rvalid (>=1)
WR_LATENCY, 1, cycles from last W handshake to bvalid (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
arvalid in 1, arready out 1, araddr in 32, arid in 4, arlen in 8, arsize in 3, arburst in 2  read address channel
rvalid out 1, rready in 1, rdata out DATA_WIDTH, rresp out 2, rid out 4, rlast out 1  read data channel
awvalid in 1, awready out 1, awaddr in 32, awid in 4, awlen in 8, awsize in 3, awburst in 2  write address channel
wvalid in 1, wready out 1, wdata in DATA_WIDTH, wstrb in 4, wlast in 1  write data channel
bvalid out 1, bready in 1, bresp out 2, bid out 4  write response channel

Behaviour:
- Reset (rst=0, async): state IDLE; arready, awready, wready, rvalid, bvalid, rlast = 0; rdata, rresp, rid, bresp, bid = 0; counters cleared. Array contents not reset.
- FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, WR_RESP.
- IDLE: arready=1; awready = ~arvalid (read wins simultaneous requests). AR handshake latches addr/id/len/size/burst -> RD_WAIT. AW handshake (no arvalid) latches -> WR_DATA.
- RD_WAIT: counts RD_LATENCY cycles, then RD_DATA with rvalid=1.
- RD_DATA: rdata = full aligned word at current address (master extracts bytes); rid = latched arid; rlast=1 on beat arlen. Outputs held stable while rvalid & ~rready. On rvalid&rready: last beat -> IDLE, rvalid=0, rlast=0 same edge; else advance address and present next beat next cycle (no extra latency).
- WR_DATA: wready=1. On wvalid&wready: bytes with wstrb[i]=1 written to array if request valid. Beat counter increments. On wlast -> WR_WAIT.
- WR_WAIT: counts WR_LATENCY cycles, then WR_RESP, bvalid=1, bid = latched awid.
- WR_RESP: bvalid/bresp/bid held until bready; then IDLE.
- Address: in range iff BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS; index = (addr-BASE_ADDR)>>2 (low 2 bits ignored for array access).
- Burst: FIXED (00) keeps address; INCR (01) adds 1<<size per beat; WRAP (10) and 2'b11 unsupported.
- Errors: per-beat out-of-range -> rresp=2'b10, rdata=0; write beat discarded. Unsupported burst or size>2 -> whole transaction SLVERR, no array access. Write: bresp=2'b10 if any beat erred or wlast beat count != awlen+1; extra beats beyond awlen+1 without wlast are absorbed and flagged. Otherwise OKAY (00).
- Only one outstanding transaction; arready/awready low outside IDLE.
- Reset mid-transaction aborts immediately; partial writes already committed remain.

Test Plan:
- Write awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=4'hF, id=1 -> bvalid after 1 cycle, bresp=00, bid=1; then read same addr, arsize=2 -> rdata=0xDEADBEEF, rlast=1, rresp=00, rid=1, rvalid 1 cycle after AR handshake.
- Byte write 0x8000_0011 wdata=0x0000AB00 wstrb=4'b0010 over 0xDEADBEEF -> read returns 0xDEADABEF.
- INCR read arlen=3 from 0x8000_0000 with rready toggling -> 4 beats words 0..3 in order, data stable while stalled, rlast only on 4th.
- Read araddr=0x0000_0000 -> rresp=10, rdata=0; write to 0x9000_0000 -> bresp=10, array unchanged.
- arvalid and awvalid asserted same cycle -> read handshakes first, awready=0 until read completes, then write completes OKAY.
- Assert rst=0 during RD_WAIT -> rvalid=0 and arready=0 immediately; after release, new read completes normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4-subset slave fronting a word-addressed SRAM; one transaction at a time,
// fixed read/write latency, byte strobes, FIXED/INCR bursts, SLVERR on bad requests.
module axi_sram_slave #(
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          RD_LATENCY = 1,
    parameter int          WR_LATENCY = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,      // active-low, asynchronous
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [31:0]             i_araddr,
    input  logic [3:0]              i_arid,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic [3:0]              o_rid,
    output logic                    o_rlast,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [31:0]             i_awaddr,
    input  logic [3:0]              i_awid,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [1:0]              o_bresp,
    output logic [3:0]              o_bid
);

    localparam int          IDX_W  = $clog2(MEM_WORDS);
    localparam int          STRB_W = DATA_WIDTH / 8;
    localparam logic [31:0] SPAN   = 32'(4 * MEM_WORDS);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_RD_DATA, S_WR_DATA, S_WR_WAIT, S_WR_RESP
    } state_t;

    state_t              r_state, w_next;
    logic                r_live;
    logic [31:0]         r_addr;
    logic [3:0]          r_id;
    logic [7:0]          r_len;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic [8:0]          r_beat;
    logic [7:0]          r_lat;
    logic                r_werr;
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic                w_ar_hs, w_aw_hs, w_in_range, w_bad, w_beat_ok, w_rd_last, w_we;
    logic [31:0]         w_off, w_next_addr;
    logic [IDX_W-1:0]    w_idx;

    // Handshakes only open one cycle after reset release; read wins a tie.
    assign w_ar_hs     = (r_state == S_IDLE) && r_live && i_arvalid;
    assign w_aw_hs     = (r_state == S_IDLE) && r_live && i_awvalid && !i_arvalid;

    assign w_off       = r_addr - BASE_ADDR;
    assign w_in_range  = (r_addr >= BASE_ADDR) && (w_off < SPAN);
    assign w_idx       = w_off[IDX_W+1:2];
    assign w_bad       = r_burst[1] || (r_size > 3'd2);
    assign w_beat_ok   = !w_bad && w_in_range;
    assign w_next_addr = (r_burst == 2'b01) ? r_addr + (32'd1 << r_size) : r_addr;
    assign w_rd_last   = (r_beat == {1'b0, r_len});
    assign w_we        = (r_state == S_WR_DATA) && i_wvalid && w_beat_ok && (r_beat <= {1'b0, r_len});

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_ar_hs) w_next = S_RD_WAIT;
                       else if (w_aw_hs) w_next = S_WR_DATA;
            S_RD_WAIT: if (r_lat == 8'(RD_LATENCY - 1)) w_next = S_RD_DATA;
            S_RD_DATA: if (i_rready && w_rd_last) w_next = S_IDLE;
            S_WR_DATA: if (i_wvalid && i_wlast) w_next = S_WR_WAIT;
            S_WR_WAIT: if (r_lat == 8'(WR_LATENCY - 1)) w_next = S_WR_RESP;
            S_WR_RESP: if (i_bready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_arready = 1'b0;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_rvalid  = 1'b0;
        o_rdata   = '0;
        o_rresp   = OKAY;
        o_rid     = '0;
        o_rlast   = 1'b0;
        o_bvalid  = 1'b0;
        o_bresp   = OKAY;
        o_bid     = '0;
        unique case (r_state)
            S_IDLE: begin
                o_arready = r_live;
                o_awready = r_live && !i_arvalid;
            end
            S_RD_DATA: begin
                o_rvalid = 1'b1;
                o_rdata  = w_beat_ok ? r_mem[w_idx] : '0;
                o_rresp  = w_beat_ok ? OKAY : SLVERR;
                o_rid    = r_id;
                o_rlast  = w_rd_last;
            end
            S_WR_DATA: o_wready = 1'b1;
            S_WR_RESP: begin
                o_bvalid = 1'b1;
                o_bresp  = r_werr ? SLVERR : OKAY;
                o_bid    = r_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_live  <= 1'b0;
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
            r_werr  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_ar_hs) begin
                r_addr  <= i_araddr;
                r_id    <= i_arid;
                r_len   <= i_arlen;
                r_size  <= i_arsize;
                r_burst <= i_arburst;
                r_beat  <= '0;
                r_lat   <= '0;
            end else if (w_aw_hs) begin
                r_addr  <= i_awaddr;
                r_id    <= i_awid;
                r_len   <= i_awlen;
                r_size  <= i_awsize;
                r_burst <= i_awburst;
                r_beat  <= '0;
                r_lat   <= '0;
                r_werr  <= 1'b0;
            end
            unique case (r_state)
                S_RD_WAIT, S_WR_WAIT: r_lat <= r_lat + 8'd1;
                S_RD_DATA: if (i_rready && !w_rd_last) begin
                    r_addr <= w_next_addr;
                    r_beat <= r_beat + 9'd1;
                end
                S_WR_DATA: if (i_wvalid) begin
                    // Beat counter saturates so runaway bursts never alias back into range.
                    r_addr <= w_next_addr;
                    r_beat <= (r_beat == 9'h1FF) ? r_beat : r_beat + 9'd1;
                    r_werr <= r_werr || !w_beat_ok || (r_beat > {1'b0, r_len})
                              || (i_wlast && (r_beat != {1'b0, r_len}));
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array is deliberately not reset; contents survive a mid-transaction reset.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (i_wstrb[i]) r_mem[w_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a byte-level memory model feeds read/write
// response queues that are popped and compared as the DUT answers.
module tb_axi_sram_slave;

    localparam int          RD_LAT = 1;
    localparam int          WR_LAT = 1;
    localparam int          WORDS  = 1024;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic        i_clk, i_rst;
    logic        i_arvalid, o_arready;
    logic [31:0] i_araddr;
    logic [3:0]  i_arid;
    logic [7:0]  i_arlen;
    logic [2:0]  i_arsize;
    logic [1:0]  i_arburst;
    logic        o_rvalid, i_rready;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;
    logic [3:0]  o_rid;
    logic        o_rlast;
    logic        i_awvalid, o_awready;
    logic [31:0] i_awaddr;
    logic [3:0]  i_awid;
    logic [7:0]  i_awlen;
    logic [2:0]  i_awsize;
    logic [1:0]  i_awburst;
    logic        i_wvalid, o_wready;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_wlast;
    logic        o_bvalid, i_bready;
    logic [1:0]  o_bresp;
    logic [3:0]  o_bid;

    axi_sram_slave #(
        .DATA_WIDTH(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE),
        .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr), .i_arid(i_arid),
        .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
        .o_rid(o_rid), .o_rlast(o_rlast),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awid(i_awid),
        .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .i_wlast(i_wlast),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp), .o_bid(o_bid)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } rd_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    rd_exp_t     rd_q[$];
    b_exp_t      b_q[$];
    logic [31:0] model_mem [WORDS];
    int          n_assert = 0;
    int          n_fail   = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(4 * WORDS));
    endfunction

    function automatic logic req_ok(input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b00 || burst == 2'b01) && (size <= 3'd2);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input int i);
        return (burst == 2'b01) ? addr + 32'(i) * (32'd1 << size) : addr;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return o_arready;
            1:       return o_awready;
            default: return o_wready;
        endcase
    endfunction

    task automatic wait_ready(input string tag, input int sel);
        int t = 0;
        while (!ready_of(sel) && t < 20) begin
            @(negedge i_clk); #1;
            t++;
        end
        check({tag, "_ready_timeout"}, 32'(t < 20), 32'd1);
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input string tag);
        i_araddr  = addr;
        i_arid    = id;
        i_arlen   = len;
        i_arsize  = size;
        i_arburst = burst;
        i_arvalid = 1'b1;
        #1;
        check({tag, "_awready_blocked"}, 32'(o_awready), 32'd0);
        wait_ready({tag, "_ar"}, 0);
        @(negedge i_clk); #1;
        i_arvalid = 1'b0;
    endtask

    task automatic r_collect(input logic toggle, input string tag);
        int lat = 0;
        int cyc = 0;
        while (!o_rvalid && lat < 20) begin
            @(negedge i_clk); #1;
            lat++;
        end
        check({tag, "_rd_latency"}, 32'(lat), 32'(RD_LAT));
        while (rd_q.size() > 0 && cyc < 200) begin
            if (o_rvalid) begin
                check({tag, "_rdata"}, o_rdata, rd_q[0].data);
                check({tag, "_rresp"}, 32'(o_rresp), 32'(rd_q[0].resp));
                check({tag, "_rid"}, 32'(o_rid), 32'(rd_q[0].id));
                check({tag, "_rlast"}, 32'(o_rlast), 32'(rd_q[0].last));
                check({tag, "_ready_busy"}, 32'({o_arready, o_awready}), 32'd0);
                i_rready = !toggle || (cyc % 2 == 1);
                if (i_rready) void'(rd_q.pop_front());
            end else begin
                check({tag, "_rvalid_gap"}, 32'(o_rvalid), 32'd1);
                i_rready = 1'b0;
            end
            @(negedge i_clk); #1;
            cyc++;
        end
        check({tag, "_rd_timeout"}, 32'(cyc < 200), 32'd1);
        rd_q.delete();
        i_rready = 1'b0;
        check({tag, "_rvalid_end"}, 32'({o_rvalid, o_rlast}), 32'd0);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic toggle, input string tag);
        logic [31:0] a;
        logic        ok;
        for (int i = 0; i <= int'(len); i++) begin
            a  = beat_addr(addr, size, burst, i);
            ok = req_ok(size, burst) && addr_ok(a);
            rd_q.push_back('{ok ? model_mem[word_of(a)] : 32'd0, ok ? 2'b00 : 2'b10, id, i == int'(len)});
        end
        ar_send(addr, id, len, size, burst, tag);
        r_collect(toggle, tag);
    endtask

    task automatic b_collect(input int hold, input string tag);
        int     lat = 0;
        b_exp_t e;
        while (!o_bvalid && lat < 20) begin
            @(negedge i_clk); #1;
            lat++;
        end
        check({tag, "_wr_latency"}, 32'(lat), 32'(WR_LAT));
        e = b_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            check({tag, "_bvalid_hold"}, 32'(o_bvalid), 32'd1);
            @(negedge i_clk); #1;
        end
        check({tag, "_bresp"}, 32'(o_bresp), 32'(e.resp));
        check({tag, "_bid"}, 32'(o_bid), 32'(e.id));
        i_bready = 1'b1;
        @(negedge i_clk); #1;
        i_bready = 1'b0;
        check({tag, "_bvalid_end"}, 32'(o_bvalid), 32'd0);
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                               input logic [31:0] data0, input logic [3:0] strb,
                               input int hold, input string tag);
        logic        err;
        logic [31:0] a, d;
        err = !req_ok(size, burst) || (nbeats != int'(len) + 1);
        for (int i = 0; i < nbeats; i++) begin
            a = beat_addr(addr, size, burst, i);
            d = data0 + 32'(i);
            if (!addr_ok(a)) err = 1'b1;
            else if (req_ok(size, burst) && i <= int'(len)) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_mem[word_of(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
        b_q.push_back('{err ? 2'b10 : 2'b00, id});
        i_awaddr  = addr;
        i_awid    = id;
        i_awlen   = len;
        i_awsize  = size;
        i_awburst = burst;
        i_awvalid = 1'b1;
        wait_ready({tag, "_aw"}, 1);
        @(negedge i_clk); #1;
        i_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            i_wdata  = data0 + 32'(i);
            i_wstrb  = strb;
            i_wlast  = (i == nbeats - 1);
            i_wvalid = 1'b1;
            wait_ready({tag, "_w"}, 2);
            @(negedge i_clk); #1;
        end
        i_wvalid = 1'b0;
        i_wlast  = 1'b0;
        b_collect(hold, tag);
    endtask

    initial begin
        i_rst = 1'b0;
        i_arvalid = 0; i_araddr = '0; i_arid = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0;
        i_rready = 0;
        i_awvalid = 0; i_awaddr = '0; i_awid = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0;
        i_wvalid = 0; i_wdata = '0; i_wstrb = '0; i_wlast = 0;
        i_bready = 0;

        #12;
        check("rst_readies", 32'({o_arready, o_awready, o_wready}), 32'd0);
        check("rst_valids", 32'({o_rvalid, o_bvalid, o_rlast}), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_ids_resps", 32'({o_rresp, o_rid, o_bresp, o_bid}), 32'd0);
        @(negedge i_clk); #1;
        i_rst = 1'b1;
        @(negedge i_clk); #1;

        // Preload words 0..3 with an INCR burst, then the single-word write/read pair.
        write_burst(BASE, 4'd2, 8'd3, 3'd2, 2'b01, 4, 32'h1111_0000, 4'hF, 0, "wr_incr4");
        write_burst(BASE + 32'h10, 4'd1, 8'd0, 3'd2, 2'b01, 1, 32'hDEAD_BEEF, 4'hF, 0, "wr_single");
        read_burst(BASE + 32'h10, 4'd1, 8'd0, 3'd2, 2'b01, 1'b0, "rd_single");

        write_burst(BASE + 32'h11, 4'd3, 8'd0, 3'd0, 2'b01, 1, 32'h0000_AB00, 4'b0010, 0, "wr_byte");
        read_burst(BASE + 32'h10, 4'd3, 8'd0, 3'd2, 2'b01, 1'b0, "rd_byte");
        check("model_byte_merge", model_mem[4], 32'hDEAD_ABEF);

        read_burst(BASE, 4'd6, 8'd3, 3'd2, 2'b01, 1'b1, "rd_incr4_stall");
        read_burst(BASE + 32'h4, 4'd7, 8'd1, 3'd2, 2'b00, 1'b0, "rd_fixed");

        read_burst(32'h0000_0000, 4'd8, 8'd0, 3'd2, 2'b01, 1'b0, "rd_oor");
        write_burst(32'h9000_0000, 4'd9, 8'd0, 3'd2, 2'b01, 1, 32'h1234_5678, 4'hF, 2, "wr_oor");
        read_burst(BASE + 32'h10, 4'd9, 8'd0, 3'd2, 2'b01, 1'b0, "rd_after_oor");

        read_burst(BASE, 4'd10, 8'd1, 3'd2, 2'b10, 1'b0, "rd_wrap");
        read_burst(BASE, 4'd11, 8'd0, 3'd3, 2'b01, 1'b0, "rd_size3");

        // Short burst (wlast early) and overlong burst (extra beat absorbed).
        write_burst(BASE + 32'h30, 4'd12, 8'd1, 3'd2, 2'b01, 1, 32'hCAFE_0030, 4'hF, 0, "wr_short");
        write_burst(BASE + 32'h40, 4'd13, 8'd1, 3'd2, 2'b01, 2, 32'h5555_0040, 4'hF, 0, "wr_pre40");
        write_burst(BASE + 32'h40, 4'd14, 8'd0, 3'd2, 2'b01, 2, 32'hAAAA_0040, 4'hF, 0, "wr_extra");
        read_burst(BASE + 32'h40, 4'd14, 8'd1, 3'd2, 2'b01, 1'b0, "rd_extra");
        check("model_extra_kept", model_mem[17], 32'h5555_0041);

        // Simultaneous AR/AW: the write address waits on the bus through the read.
        i_awaddr = BASE + 32'h20; i_awid = 4'd5; i_awlen = 8'd0; i_awsize = 3'd2; i_awburst = 2'b01;
        i_awvalid = 1'b1;
        read_burst(BASE + 32'h10, 4'd4, 8'd0, 3'd2, 2'b01, 1'b0, "rd_tie");
        write_burst(BASE + 32'h20, 4'd5, 8'd0, 3'd2, 2'b01, 1, 32'h0BAD_F00D, 4'hF, 0, "wr_tie");
        read_burst(BASE + 32'h20, 4'd5, 8'd0, 3'd2, 2'b01, 1'b0, "rd_tie_check");

        // Reset while waiting on read latency.
        ar_send(BASE + 32'h10, 4'd15, 8'd0, 3'd2, 2'b01, "rd_abort");
        i_rst = 1'b0;
        #1;
        check("abort_arready", 32'(o_arready), 32'd0);
        check("abort_rvalid_now", 32'(o_rvalid), 32'd0);
        @(negedge i_clk); #1;
        check("abort_rvalid_later", 32'({o_rvalid, o_rlast}), 32'd0);
        check("abort_rid", 32'(o_rid), 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk); #1;
        read_burst(BASE + 32'h10, 4'd15, 8'd0, 3'd2, 2'b01, 1'b0, "rd_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
